// File: rtl/rice_symbol_unpacker.sv
// Streaming Golomb-Rice symbol decoder: 64-bit MSB-first bit buffer fed by 32-bit words,
// one (quotient << k) | remainder symbol per cycle on a valid/ready output.

module count_lead_zero #(
  parameter int W_IN  = 17,
  parameter int W_OUT = 5
) (
  input  logic [W_IN-1:0]  i_data,
  output logic [W_OUT-1:0] o_count
);

  // Lowest-to-highest scan so the most significant set bit wins; all-zero gives W_IN.
  always_comb begin
    o_count = W_OUT'(W_IN);
    for (int i = 0; i < W_IN; i++) begin
      o_count = i_data[i] ? W_OUT'(W_IN - 1 - i) : o_count;
    end
  end

endmodule

module rice_symbol_unpacker #(
  parameter int W_WORD = 32,
  parameter int Q_MAX  = 16,
  parameter int W_K    = 4,
  parameter int W_VAL  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_K-1:0]    k_in,
  input  logic              flush,
  input  logic [W_WORD-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_VAL-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  localparam int W_BUF  = 2 * W_WORD;
  localparam int W_FILL = $clog2(W_BUF + 1);
  localparam int W_Z    = $clog2(Q_MAX + 2);

  logic [W_BUF-1:0]  r_buf;
  logic [W_FILL-1:0] r_fill;
  logic [W_K-1:0]    r_k;
  logic [W_VAL-1:0]  r_out_data;
  logic              r_out_valid;
  logic              r_err;

  logic [W_Z-1:0]    w_z;
  logic [W_FILL-1:0] w_len;
  logic [W_FILL-1:0] w_shift;
  logic [W_FILL-1:0] w_fill_sh;
  logic [W_FILL-1:0] w_fill_nxt;
  logic [W_BUF-1:0]  w_mask;
  logic [W_BUF-1:0]  w_buf_sh;
  logic [W_BUF-1:0]  w_word_ext;
  logic [W_BUF-1:0]  w_buf_nxt;
  logic [W_VAL-1:0]  w_val;
  logic              w_complete;
  logic              w_err_cond;
  logic              w_dec;
  logic              w_accept;
  logic              w_in_ready;

  count_lead_zero #(
    .W_IN  (Q_MAX + 1),
    .W_OUT (W_Z)
  ) u_clz (
    .i_data  (r_buf[W_BUF-1 -: Q_MAX+1]),
    .o_count (w_z)
  );

  // Symbol decode, acceptance and next buffer/fill computation.
  always_comb begin
    w_in_ready = (r_fill <= W_FILL'(W_WORD)) && !r_err && !flush && rst_n;
    w_accept   = in_valid && w_in_ready;
    w_len      = W_FILL'(w_z) + W_FILL'(1) + W_FILL'(r_k);
    w_complete = (w_z <= W_Z'(Q_MAX)) && (r_fill >= w_len);
    w_err_cond = (w_z == W_Z'(Q_MAX + 1)) && (r_fill >= W_FILL'(Q_MAX + 1));
    w_dec      = w_complete && !r_err && (!r_out_valid || out_ready);
    // Right-align the whole symbol, then keep only its k remainder bits.
    w_mask     = ~({W_BUF{1'b1}} << r_k);
    w_val      = (W_VAL'(w_z) << r_k)
               | W_VAL'((r_buf >> (W_FILL'(W_BUF) - w_len)) & w_mask);
    w_shift    = w_dec ? w_len : {W_FILL{1'b0}};
    w_buf_sh   = r_buf << w_shift;
    w_fill_sh  = r_fill - w_shift;
    w_word_ext = {in_data, {W_WORD{1'b0}}} >> w_fill_sh;
    w_buf_nxt  = w_accept ? (w_buf_sh | w_word_ext) : w_buf_sh;
    w_fill_nxt = w_accept ? (w_fill_sh + W_FILL'(W_WORD)) : w_fill_sh;
  end

  // Buffer, output register and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= {W_BUF{1'b0}};
      r_fill      <= {W_FILL{1'b0}};
      r_k         <= {W_K{1'b0}};
      r_out_data  <= {W_VAL{1'b0}};
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (flush) begin
      r_buf       <= {W_BUF{1'b0}};
      r_fill      <= {W_FILL{1'b0}};
      r_k         <= k_in;
      r_out_data  <= {W_VAL{1'b0}};
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_buf  <= w_buf_nxt;
      r_fill <= w_fill_nxt;
      if (w_dec) begin
        r_out_data  <= w_val;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      if (w_err_cond) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_rice_symbol_unpacker.sv
// Directed and randomized bench for rice_symbol_unpacker against a bit-queue reference model.

module tb_rice_symbol_unpacker;

  logic        clk;
  logic        rst_n;
  logic [3:0]  k_in;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: the buffer is just a queue of bits, head first.
  bit          m_q[$];
  int          m_k;
  bit          m_err;
  bit          m_ov;
  logic [31:0] m_od;

  logic [31:0] dut_taken[$];
  int          exp_q[$];

  rice_symbol_unpacker #(
    .W_WORD (32),
    .Q_MAX  (16),
    .W_K    (4),
    .W_VAL  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .k_in      (k_in),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_q.delete();
    m_k   = k;
    m_err = 1'b0;
    m_ov  = 1'b0;
    m_od  = 32'h0;
  endtask

  function automatic bit model_ready(input bit fl);
    return (m_q.size() <= 32) && !m_err && !fl;
  endfunction

  // One clock edge of the specified behaviour, written over the bit queue.
  task automatic model_step(input bit fl, input logic [3:0] kin, input bit iv,
                            input logic [31:0] d, input bit ordy);
    int  z;
    int  val;
    bit  rdy;
    bit  complete;
    bit  errc;
    if (fl) begin
      model_reset(int'(kin));
    end else begin
      rdy = model_ready(1'b0);
      z = -1;
      for (int i = 0; i < 17 && i < m_q.size(); i++) begin
        if (m_q[i] && z < 0) z = i;
      end
      complete = (z >= 0) && (m_q.size() >= z + 1 + m_k);
      errc     = (z < 0) && (m_q.size() >= 17);
      if (complete && !m_err && (!m_ov || ordy)) begin
        val = z;
        for (int j = 0; j < m_k; j++) val = val * 2 + int'(m_q[z + 1 + j]);
        repeat (z + 1 + m_k) void'(m_q.pop_front());
        m_ov = 1'b1;
        m_od = val;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (errc) m_err = 1'b1;
      if (iv && rdy) begin
        for (int b = 31; b >= 0; b--) m_q.push_back(d[b]);
      end
    end
  endtask

  task automatic cyc(input bit fl, input logic [3:0] kin, input bit iv,
                     input logic [31:0] d, input bit ordy);
    flush     = fl;
    k_in      = kin;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, model_ready(fl));
    if (out_valid && ordy) dut_taken.push_back(out_data);
    @(posedge clk);
    model_step(fl, kin, iv, d, ordy);
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("err", err, m_err);
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) cyc(1'b0, 4'($urandom_range(0, 15)), 1'b0, 32'h0, ordy);
  endtask

  task automatic chk_list(input string tag);
    chk({tag, "_count"}, dut_taken.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dut_taken.size(); i++) begin
      chk(tag, dut_taken[i], exp_q[i]);
    end
  endtask

  function automatic logic [31:0] rand_word();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return $urandom;
    else if (sel == 1) return $urandom & $urandom & $urandom;
    else if (sel == 2) return $urandom | $urandom;
    else return $urandom & $urandom;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; k_in = 4'd0; in_valid = 1'b0;
    in_data = 32'h0; out_ready = 1'b0;
    model_reset(0);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed symbols, k=2.
    dut_taken.delete();
    cyc(1'b1, 4'd2, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 4'd9, 1'b1, 32'h58FF_FFFF, 1'b1);
    idle(14, 1'b1);
    exp_q = '{5, 0, 7, 3, 3, 3, 3, 3, 3, 3};
    chk_list("mixed");
    chk("mixed_fill", 32'(dut.r_fill), 32'd0);
    chk("mixed_err", err, 1'b0);

    // k=0 run of terminators, with first-symbol latency.
    dut_taken.delete();
    cyc(1'b1, 4'd0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 4'd5, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("lat_before", out_valid, 1'b0);
    idle(1, 1'b1);
    chk("lat_first", out_valid, 1'b1);
    idle(34, 1'b1);
    exp_q.delete();
    repeat (32) exp_q.push_back(0);
    chk_list("ones_k0");

    // Prefix split across a word boundary.
    dut_taken.delete();
    cyc(1'b1, 4'd0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 32'h3FFF_FFFF, 1'b1);
    idle(66, 1'b1);
    exp_q.delete();
    repeat (31) exp_q.push_back(0);
    exp_q.push_back(3);
    repeat (29) exp_q.push_back(0);
    chk_list("split");

    // Prefix error and recovery through flush.
    dut_taken.delete();
    cyc(1'b1, 4'd0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 32'h0000_0000, 1'b1);
    chk("err_not_yet", err, 1'b0);
    idle(1, 1'b1);
    chk("err_set", err, 1'b1);
    chk("err_in_ready", in_ready, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle(3, 1'b1);
    chk("err_no_output", dut_taken.size(), 0);
    cyc(1'b1, 4'd0, 1'b0, 32'h0, 1'b1);
    chk("flush_err", err, 1'b0);
    flush = 1'b0;
    #1;
    chk("flush_in_ready", in_ready, 1'b1);

    // Backpressure until the buffer is past half full, then drain.
    dut_taken.delete();
    cyc(1'b1, 4'd2, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 32'h58FF_FFFF, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    repeat (4) cyc(1'b0, 4'd0, 1'b1, 32'h1234_5678, 1'b0);
    chk("bp_data", out_data, 32'd5);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    idle(26, 1'b1);
    exp_q = '{5, 0, 7, 3, 3, 3, 3, 3, 3, 3};
    repeat (10) exp_q.push_back(3);
    chk_list("bp_drain");

    // Randomized traffic against the model, flushing with a fresh k per segment.
    for (int seg = 0; seg < 6; seg++) begin
      cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0, 32'h0, 1'b1);
      for (int c = 0; c < 200; c++) begin
        cyc(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
            rand_word(), ($urandom_range(0, 3) != 0));
      end
    end

    // Asynchronous reset mid-stream.
    cyc(1'b1, 4'd1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 32'h9FFF_FFFF, 1'b0);
    idle(2, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_err", err, 1'b0);
    model_reset(0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_in_ready", in_ready, 1'b1);
    chk("arst_no_stale", out_valid, 1'b0);
    for (int c = 0; c < 150; c++) begin
      cyc(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6),
          rand_word(), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
